// File: rtl/ad9945_cfg_ctrl_if.sv
//------------------------------------------------------------------------------
// ad9945_cfg_ctrl_if
// Runtime register-write channel into the AD9945 configuration controller.
//   wr_valid : requester has a write pending (hold until accepted)
//   wr_addr  : AD9945 register address (3 bits, all eight codes passed through)
//   wr_data  : 12-bit register data
//   wr_ready : controller can accept; a write transfers when valid & ready
// master modport = requester side, slave modport = controller side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface ad9945_cfg_ctrl_if;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/ad9945_cfg_ctrl.sv
//------------------------------------------------------------------------------
// ad9945_cfg_ctrl
// Serial-port configuration controller for the AD9945 AFE (TCD1290D readout).
// After reset it waits INIT_DLY cycles, loads four default registers
// (operation, control, clamp, VGA) over the SL/SCK/SDATA 3-wire port, then
// serves runtime writes, accepting new ones only during line blanking.
//
// Ports
//   sys_clk   : system clock (100 MHz, shared with the CCD driver)
//   sys_rst   : synchronous active-high reset
//   os_tvalid : CCD line active; blocks new write acceptance while high
//   wr        : runtime write channel (slave modport of ad9945_cfg_ctrl_if)
//   SL        : serial load, active low, frames one 16-bit word
//   SCK       : serial clock, idles low, AFE samples on its rising edge
//   SDATA     : serial data, LSB first {data[11:0], 1'b0, addr[2:0]}
//   cfg_done  : default load complete, sticky until reset
//   busy      : a frame or its trailing gap is in progress
//   vga_gain  : shadow of the last data written to address 3
//
// state      | meaning
// -----------+------------------------------------------------------------
// INIT_WAIT  | post-reset settling delay, INIT_DLY cycles
// LOAD       | latch frame word (default table entry or captured request)
// SETUP      | SL low, SDATA = bit 0, SCK low for SCK_HALF cycles
// SHIFT      | 16 SCK periods, SDATA advances after each high phase
// HOLD       | SL still low, SCK low for SCK_HALF cycles; shadow update
// GAP        | SL high for GAP cycles; next default entry or go idle
// IDLE       | wr_ready = cfg_done & ~os_tvalid; wait for a handshake
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ad9945_cfg_ctrl #(
  parameter int          SCK_HALF = 5,
  parameter int          INIT_DLY = 1000,
  parameter int          GAP      = 4,
  parameter logic [11:0] DEF_OPR  = 12'h000,
  parameter logic [11:0] DEF_CTL  = 12'h000,
  parameter logic [11:0] DEF_CLP  = 12'h080,
  parameter logic [11:0] DEF_VGA  = 12'h100
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               os_tvalid,
  ad9945_cfg_ctrl_if.slave   wr,
  output logic               SL,
  output logic               SCK,
  output logic               SDATA,
  output logic               cfg_done,
  output logic               busy,
  output logic [11:0]        vga_gain
);

  localparam logic [2:0] S_INIT_WAIT = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_SETUP     = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;
  localparam logic [2:0] S_IDLE      = 3'd6;

  localparam int INIT_W  = (INIT_DLY > 1) ? $clog2(INIT_DLY + 1) : 1;
  localparam int TMR_MAX = (SCK_HALF > GAP) ? SCK_HALF : GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_DLY - 1);
  localparam logic [TMR_W-1:0]  HALF_LD   = TMR_W'(SCK_HALF - 1);
  localparam logic [TMR_W-1:0]  GAP_LD    = TMR_W'(GAP - 1);

  logic [2:0]        state;
  logic [INIT_W-1:0] init_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [3:0]        bit_cnt;
  logic [1:0]        init_idx;
  logic [14:0]       shreg;
  logic [2:0]        frm_addr;
  logic [11:0]       frm_data;
  logic [2:0]        req_addr;
  logic [11:0]       req_data;

  logic [11:0]       def_data;
  logic [2:0]        load_addr;
  logic [11:0]       load_data;
  logic [15:0]       load_word;

  always_comb begin
    def_data = DEF_OPR;
    case (init_idx)
      2'd1:    def_data = DEF_CTL;
      2'd2:    def_data = DEF_CLP;
      2'd3:    def_data = DEF_VGA;
      default: def_data = DEF_OPR;
    endcase
  end

  // cfg_done is only ever set on the way out of the last default frame, so
  // any LOAD seen with it high is serving a captured runtime request.
  always_comb begin
    load_addr = cfg_done ? req_addr : {1'b0, init_idx};
    load_data = cfg_done ? req_data : def_data;
    load_word = {load_data, 1'b0, load_addr};
  end

  assign busy = (state == S_LOAD) || (state == S_SETUP) || (state == S_SHIFT) ||
                (state == S_HOLD) || (state == S_GAP);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_INIT_WAIT;
      init_cnt    <= '0;
      tmr         <= '0;
      bit_cnt     <= '0;
      init_idx    <= '0;
      shreg       <= '0;
      frm_addr    <= '0;
      frm_data    <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      SL          <= 1'b1;
      SCK         <= 1'b0;
      SDATA       <= 1'b0;
      cfg_done    <= 1'b0;
      vga_gain    <= DEF_VGA;
      wr.wr_ready <= 1'b0;
    end else begin
      wr.wr_ready <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (init_cnt == INIT_LAST) begin
            init_cnt <= '0;
            init_idx <= '0;
            state    <= S_LOAD;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          frm_addr <= load_addr;
          frm_data <= load_data;
          shreg    <= load_word[15:1];
          SDATA    <= load_word[0];
          SL       <= 1'b0;
          tmr      <= HALF_LD;
          state    <= S_SETUP;
        end

        S_SETUP: begin
          if (tmr == '0) begin
            tmr     <= HALF_LD;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // SCK itself tells which half of the bit period we are in.
        S_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            tmr <= HALF_LD;
            if (!SCK) begin
              SCK <= 1'b1;
            end else begin
              SCK <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= S_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                SDATA   <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end
          end
        end

        S_HOLD: begin
          if (tmr == '0) begin
            SL    <= 1'b1;
            tmr   <= GAP_LD;
            state <= S_GAP;
            if (frm_addr == 3'd3) begin
              vga_gain <= frm_data;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_GAP: begin
          if (tmr == '0) begin
            if (init_idx != 2'd3) begin
              init_idx <= init_idx + 1'b1;
              state    <= S_LOAD;
            end else begin
              cfg_done <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // Acceptance is decided on the registered wr_ready, so an os_tvalid
        // rising in the same cycle as wr_valid cannot retract an offer.
        S_IDLE: begin
          if (wr.wr_valid && wr.wr_ready) begin
            req_addr <= wr.wr_addr;
            req_data <= wr.wr_data;
            state    <= S_LOAD;
          end else begin
            wr.wr_ready <= cfg_done & ~os_tvalid;
          end
        end

        default: state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule
